// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: fixed-latency issue scoreboard that stalls on RAW hazards against in-flight writes.
// Optional writeback-bus forwarding is enabled by defining PIPE_HAZARD_FWD_EN.
module pipe_hazard_ctrl #(
    parameter int LAT = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [3:0]  src1_ad,
    input  logic [3:0]  src2_ad,
    input  logic [3:0]  dst_ad,
    input  logic        use_src1,
    input  logic        use_src2,
    input  logic        wr_dst,
    input  logic        hold,
    output logic        issue_en,
    output logic        stall,
    output logic        wb_valid,
    output logic [3:0]  wb_ad,
    output logic        fwd1,
    output logic        fwd2,
    output logic [15:0] stall_cnt
);

`ifdef PIPE_HAZARD_FWD_EN
    localparam int WIN = LAT - 1;
`else
    localparam int WIN = LAT;
`endif

    logic [LAT-1:0] slot_v;
    logic [3:0]     slot_ad [LAT];
    logic           haz1;
    logic           haz2;
    logic           hazard;

    // The issuing instruction's own dst is not yet in any slot, so it never matches itself.
    always_comb begin
        haz1 = 1'b0;
        haz2 = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            if (slot_v[i] && (slot_ad[i] == src1_ad)) haz1 = 1'b1;
            if (slot_v[i] && (slot_ad[i] == src2_ad)) haz2 = 1'b1;
        end
    end

    assign hazard     = (use_src1 && haz1) || (use_src2 && haz2);
    assign inst_ready = !hold && !hazard;
    assign issue_en   = inst_valid && inst_ready;
    assign stall      = hold || (inst_valid && hazard);
    assign wb_valid   = slot_v[LAT-1] && !hold;
    assign wb_ad      = slot_ad[LAT-1];

`ifdef PIPE_HAZARD_FWD_EN
    assign fwd1 = slot_v[LAT-1] && use_src1 && (slot_ad[LAT-1] == src1_ad) && !hold;
    assign fwd2 = slot_v[LAT-1] && use_src2 && (slot_ad[LAT-1] == src2_ad) && !hold;
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            slot_v <= '0;
            for (int i = 0; i < LAT; i++) slot_ad[i] <= 4'd0;
        end else if (!hold) begin
            slot_v[0]  <= issue_en && wr_dst;
            slot_ad[0] <= issue_en ? dst_ad : 4'd0;
            for (int i = 1; i < LAT; i++) begin
                slot_v[i]  <= slot_v[i-1];
                slot_ad[i] <= slot_ad[i-1];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stall_cnt <= 16'd0;
        end else if (inst_valid && hazard && !hold && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios plus random traffic against an age-list model.
// Expectations follow PIPE_HAZARD_FWD_EN when it is defined for the build.
module tb_pipe_hazard_ctrl;
    localparam int LAT = 4;
`ifdef PIPE_HAZARD_FWD_EN
    localparam int WIN       = LAT - 1;
    localparam int EXP_STALL = 3;
    localparam int EXP_FWD   = 1;
`else
    localparam int WIN       = LAT;
    localparam int EXP_STALL = 4;
    localparam int EXP_FWD   = 0;
`endif

    logic        Clock = 1'b0;
    logic        Reset;
    logic        inst_valid;
    logic        inst_ready;
    logic [3:0]  src1_ad, src2_ad, dst_ad;
    logic        use_src1, use_src2, wr_dst;
    logic        hold;
    logic        issue_en, stall, wb_valid;
    logic [3:0]  wb_ad;
    logic        fwd1, fwd2;
    logic [15:0] stall_cnt;

    pipe_hazard_ctrl #(.LAT(LAT)) dut (
        .Clock(Clock), .Reset(Reset), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .src1_ad(src1_ad), .src2_ad(src2_ad), .dst_ad(dst_ad),
        .use_src1(use_src1), .use_src2(use_src2), .wr_dst(wr_dst), .hold(hold),
        .issue_en(issue_en), .stall(stall), .wb_valid(wb_valid), .wb_ad(wb_ad),
        .fwd1(fwd1), .fwd2(fwd2), .stall_cnt(stall_cnt)
    );

    always #5 Clock = ~Clock;

    // Model: list of in-flight writes with their age in non-held cycles since issue.
    typedef struct {logic [3:0] ad; int age;} fl_t;
    fl_t         q[$];
    logic [15:0] mcnt;
    int          cyc;
    int          n_total = 0;
    int          n_bad   = 0;
    logic [3:0]  wb_log[$];
    int          wb_cyc[$];
    logic        obs_rdy, obs_fwd1, obs_wbv;
    logic [3:0]  obs_wb_ad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic cycle();
        logic haz, f1, f2, wbv, rdy, iss, stl;
        logic [3:0] wba;
        #1;
        haz = 1'b0; f1 = 1'b0; f2 = 1'b0; wbv = 1'b0; wba = 4'd0;
        foreach (q[i]) begin
            if (q[i].age < WIN) begin
                if (use_src1 && q[i].ad == src1_ad) haz = 1'b1;
                if (use_src2 && q[i].ad == src2_ad) haz = 1'b1;
            end
            if (q[i].age == LAT - 1) begin
                wbv = !hold;
                wba = q[i].ad;
                if (EXP_FWD == 1 && !hold && use_src1 && q[i].ad == src1_ad) f1 = 1'b1;
                if (EXP_FWD == 1 && !hold && use_src2 && q[i].ad == src2_ad) f2 = 1'b1;
            end
        end
        rdy = !hold && !haz;
        iss = inst_valid && rdy;
        stl = hold || (inst_valid && haz);
        chk("inst_ready", inst_ready, rdy);
        chk("issue_en", issue_en, iss);
        chk("stall", stall, stl);
        chk("wb_valid", wb_valid, wbv);
        if (wbv) chk("wb_ad", wb_ad, wba);
        chk("fwd1", fwd1, f1);
        chk("fwd2", fwd2, f2);
        chk("stall_cnt", stall_cnt, mcnt);
        obs_rdy = inst_ready; obs_fwd1 = fwd1; obs_wbv = wb_valid; obs_wb_ad = wb_ad;
        if (wb_valid) begin
            wb_log.push_back(wb_ad);
            wb_cyc.push_back(cyc);
        end
        if (Reset) begin
            q.delete();
            mcnt = 16'd0;
        end else begin
            if (inst_valid && haz && !hold && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
            if (!hold) begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (q[i].age == LAT - 1) q.delete(i);
                    else q[i].age = q[i].age + 1;
                end
                if (iss && wr_dst) q.push_back('{ad: dst_ad, age: 0});
            end
        end
        cyc++;
        @(negedge Clock);
    endtask

    task automatic idle();
        inst_valid = 1'b0; use_src1 = 1'b0; use_src2 = 1'b0; wr_dst = 1'b0;
        src1_ad = 4'd0; src2_ad = 4'd0; dst_ad = 4'd0; hold = 1'b0; Reset = 1'b0;
    endtask

    task automatic set_write(input logic [3:0] a);
        idle();
        inst_valid = 1'b1; wr_dst = 1'b1; dst_ad = a;
    endtask

    task automatic set_read(input logic [3:0] a);
        idle();
        inst_valid = 1'b1; use_src1 = 1'b1; src1_ad = a; dst_ad = 4'd9;
    endtask

    // Offer a read of a until it issues; returns stall cycles seen.
    task automatic read_until_issue(input logic [3:0] a, input string tag, output int n);
        bit done;
        done = 1'b0;
        n = 0;
        set_read(a);
        for (int k = 0; k < 20 && !done; k++) begin
            cycle();
            if (obs_rdy) done = 1'b1;
            else n++;
        end
        chk({tag, "_issued"}, done, 1);
        idle();
    endtask

    initial begin
        int n, prod, first, h;
        idle();
        Reset = 1'b1;
        q.delete();
        mcnt = 16'd0;
        cyc = 0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;

        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_ad", wb_ad, 0);

        // Producer / dependent consumer.
        wb_log.delete(); wb_cyc.delete();
        set_write(4'd3);
        prod = cyc;
        cycle();
        read_until_issue(4'd3, "raw", n);
        chk("raw_stall_cycles", n, EXP_STALL);
        chk("raw_fwd1_at_issue", obs_fwd1, EXP_FWD);
        chk("raw_stall_cnt", stall_cnt, EXP_STALL);
        repeat (6) cycle();
        chk("raw_wb_count", wb_log.size(), 1);
        if (wb_log.size() > 0) begin
            chk("raw_wb_ad", wb_log[0], 3);
            chk("raw_wb_delay", wb_cyc[0] - prod, LAT);
        end

        // Back-to-back independent writes.
        wb_log.delete(); wb_cyc.delete();
        first = cyc;
        for (int r = 1; r <= 4; r++) begin
            set_write(r[3:0]);
            cycle();
            chk("b2b_ready", obs_rdy, 1);
        end
        idle();
        repeat (6) cycle();
        chk("b2b_wb_count", wb_log.size(), 4);
        for (int i = 0; i < wb_log.size() && i < 4; i++) begin
            chk("b2b_wb_ad", wb_log[i], i + 1);
            chk("b2b_wb_cyc", wb_cyc[i] - first, LAT + i);
        end

        // Hold while r5 sits in S2.
        wb_log.delete(); wb_cyc.delete();
        set_write(4'd5);
        cycle();
        idle();
        repeat (2) cycle();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_no_wb", obs_wbv, 0);
        end
        hold = 1'b0;
        h = cyc;
        repeat (5) cycle();
        chk("hold_wb_count", wb_log.size(), 1);
        if (wb_log.size() > 0) begin
            chk("hold_wb_ad", wb_log[0], 5);
            chk("hold_wb_delay", wb_cyc[0] - h, 1);
        end

        // Reset discards r6 in S1.
        set_write(4'd6);
        cycle();
        idle();
        cycle();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        wb_log.delete(); wb_cyc.delete();
        set_read(4'd6);
        cycle();
        chk("post_rst_ready", obs_rdy, 1);
        chk("post_rst_wb_ad", obs_wb_ad, 0);
        chk("post_rst_wb_valid", obs_wbv, 0);
        idle();
        repeat (6) cycle();
        chk("post_rst_wb_count", wb_log.size(), 0);
        chk("post_rst_stall_cnt", stall_cnt, 0);

        // Saturation from a preloaded counter.
        force dut.stall_cnt = 16'hFFFE;
        #1;
        release dut.stall_cnt;
        mcnt = 16'hFFFE;
        set_write(4'd7);
        cycle();
        read_until_issue(4'd7, "sat", n);
        chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
        idle();
        repeat (6) cycle();

        // Random traffic on a small address range to provoke hazards.
        for (int k = 0; k < 400; k++) begin
            Reset      = ($urandom_range(0, 63) == 0);
            hold       = ($urandom_range(0, 7) == 0);
            inst_valid = ($urandom_range(0, 3) != 0);
            src1_ad    = 4'($urandom_range(0, 3));
            src2_ad    = 4'($urandom_range(0, 3));
            dst_ad     = 4'($urandom_range(0, 3));
            use_src1   = 1'($urandom_range(0, 1));
            use_src2   = 1'($urandom_range(0, 1));
            wr_dst     = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
